adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
Sequences one AD9244 capture burst for the OFDM receive chain. It drives the streamer's 4-bit control word and watches its 32-bit status word. It counts accepted AXIS beats by snooping the streamer's tvalid/tready. It handles pre-capture flag clearing, trigger arming, a programmable post-trigger delay, a fixed-length capture, a stop handshake, and error reporting to the PS-side register block.

Parameters:
LEN_WIDTH, 16, width of the capture length, delay and beat counters
CLEAR_CYCLES, 4, cycles that clearOverRun/clearOTR are held high before arming
STOP_TIMEOUT, 64, maximum cycles to wait for streamStatus to fall after enable drops

Ports:
aclk  in  1  clock, same domain as the streamer's m00_axis_aclk
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a burst; honoured in IDLE only
abort  in  1  forces return to IDLE from any state, highest priority
err_clear  in  1  clears sticky errors; leaves ERROR for IDLE
trigger  in  1  capture trigger from the sync detector
cfg_auto_trig  in  1  if 1, ARM proceeds without trigger
cfg_test_mode  in  1  value driven on control[3] for the burst
cfg_len  in  LEN_WIDTH  beats to capture; latched at start
cfg_delay  in  LEN_WIDTH  clocks from trigger to enable; latched at start
adc_status  in  32  streamer status: [0] streamStatus, [1] overRun, [2] OTR, [31:16] overRunCount
snoop_tvalid  in  1  streamer m00_axis_tvalid
snoop_tready  in  1  downstream m00_axis_tready
adc_control  out  4  [0] streamEnable, [1] clearOverRun, [2] clearOTR, [3] testMode
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful burst completion
beat_count  out  LEN_WIDTH  beats accepted in the current/last burst
err_overrun  out  1  sticky, overrun seen during CAPTURE
err_timeout  out  1  sticky, stop handshake timed out
err_cfg  out  1  sticky, start with cfg_len==0
otr_seen  out  1  sticky, OTR seen during CAPTURE
overrun_snap  out  16  adc_status[31:16] sampled on entry to ERROR by overrun
state_out  out  3  encoded state for debug: IDLE=0 CLEAR=1 ARM=2 DELAY=3 CAPTURE=4 STOP=5 ERROR=6

Behaviour:
- Reset: state IDLE. adc_control=0, busy=0, done=0, beat_count=0, all sticky flags=0, overrun_snap=0.
- All outputs are registered. adc_control changes one cycle after the state transition that requires it.
- IDLE: adc_control=0.
  - start with cfg_len!=0: latch cfg_len/cfg_delay/cfg_test_mode, clear beat_count and otr_seen, go to CLEAR.
  - start with cfg_len==0: set err_cfg, go to ERROR.
- CLEAR: adc_control[2:1]=2'b11 for exactly CLEAR_CYCLES cycles, then ARM.
- ARM: adc_control[1:0]=0. Go to DELAY when trigger==1 or cfg_auto_trig==1. If the latched delay is 0, go straight to CAPTURE.
- DELAY: down-counter loaded with the latched delay; decrements each cycle; at 1 go to CAPTURE. Enable rises exactly latched-delay+1 cycles after the trigger cycle.
- CAPTURE:
  - adc_control[0]=1.
  - beat = snoop_tvalid & snoop_tready; beat_count increments per beat.
  - On the beat that makes beat_count==latched len, go to STOP in the same cycle; enable falls next cycle.
  - adc_status[1]==1: set err_overrun, latch overrun_snap, go to ERROR. If this coincides with the final beat, overrun wins.
  - adc_status[2]==1: set otr_seen; capture continues.
- STOP:
  - adc_control[0]=0. Beats accepted here are not counted.
  - adc_status[0]==0: pulse done, go to IDLE.
  - Otherwise, after STOP_TIMEOUT cycles: set err_timeout, go to ERROR.
- ERROR: adc_control=0 except [3]. Hold until err_clear, which clears err_overrun/err_timeout/err_cfg and returns to IDLE. otr_seen is cleared only by the next start.
- testMode: adc_control[3] equals the latched cfg_test_mode in every non-IDLE state and 0 in IDLE.
- abort: any state goes to IDLE next cycle, adc_control=0, no done pulse. Sticky flags keep their values. Same cycle as start: abort wins.
- start while busy: ignored. trigger outside ARM: ignored.
- Counters saturate rather than wrap. cfg_len max 2^LEN_WIDTH-1 is legal.
- Reset asserted mid-burst: immediate return to reset values, streamEnable drops asynchronously.

Test Plan:
- cfg_len=8, cfg_delay=0, auto_trig=1, tready tied 1, streamer valid every cycle -> CLEAR held 4 cycles, enable high for 8 beats, beat_count=8, done pulses once, state returns to 0.
- cfg_delay=5, trigger pulsed at cycle T -> adc_control[0] rises at T+6; no enable before the trigger.
- overRun forced high after beat 3 with overRunCount=0x0007 -> err_overrun=1, overrun_snap=0x0007, enable low, state=6; err_clear -> IDLE, flags 0.
- streamStatus held high after enable drop -> err_timeout set after 64 cycles, no done.
- start with cfg_len=0 -> err_cfg=1, state=6, enable never asserted.
- abort during CAPTURE at beat 4 of 16 -> IDLE next cycle, adc_control=0, beat_count=4, no done; start asserted in same cycle as abort ignored.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// rtl/adc_capture_sequencer.sv - AD9244 capture burst sequencer
// Drives the streamer control word and counts snooped AXIS beats for one burst.
module adc_capture_sequencer #(
  parameter int LEN_WIDTH    = 16,
  parameter int CLEAR_CYCLES = 4,
  parameter int STOP_TIMEOUT = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 err_clear,
  input  logic                 trigger,
  input  logic                 cfg_auto_trig,
  input  logic                 cfg_test_mode,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [LEN_WIDTH-1:0] cfg_delay,
  input  logic [31:0]          adc_status,
  input  logic                 snoop_tvalid,
  input  logic                 snoop_tready,
  output logic [3:0]           adc_control,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] beat_count,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic                 err_cfg,
  output logic                 otr_seen,
  output logic [15:0]          overrun_snap,
  output logic [2:0]           state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ARM     = 3'd2,
    S_DELAY   = 3'd3,
    S_CAPTURE = 3'd4,
    S_STOP    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam int TW = $clog2(STOP_TIMEOUT + CLEAR_CYCLES + 1);
  localparam logic [LEN_WIDTH-1:0] ONE     = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] delay_q;
  logic [LEN_WIDTH-1:0] delay_cnt;
  logic [TW-1:0]        timer;
  logic                 test_q;
  logic                 beat;
  logic                 unused_status;

  assign beat          = snoop_tvalid & snoop_tready;
  assign unused_status = ^adc_status[15:3];
  assign state_out     = state;

  // Control word is registered alongside the state it belongs to.
  function automatic logic [3:0] ctrl_for(state_t s, logic tm);
    case (s)
      S_IDLE:    ctrl_for = 4'b0000;
      S_CLEAR:   ctrl_for = {tm, 3'b110};
      S_CAPTURE: ctrl_for = {tm, 3'b001};
      default:   ctrl_for = {tm, 3'b000};
    endcase
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      adc_control  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      beat_count   <= '0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
      err_cfg      <= 1'b0;
      otr_seen     <= 1'b0;
      overrun_snap <= '0;
      len_q        <= '0;
      delay_q      <= '0;
      delay_cnt    <= '0;
      timer        <= '0;
      test_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      // Later assignments below (new errors) take precedence over a clear.
      if (err_clear) begin
        err_overrun <= 1'b0;
        err_timeout <= 1'b0;
        err_cfg     <= 1'b0;
      end
      if (abort) begin
        state       <= S_IDLE;
        adc_control <= '0;
        busy        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              test_q <= cfg_test_mode;
              busy   <= 1'b1;
              if (cfg_len == '0) begin
                err_cfg     <= 1'b1;
                state       <= S_ERROR;
                adc_control <= ctrl_for(S_ERROR, cfg_test_mode);
              end else begin
                len_q       <= cfg_len;
                delay_q     <= cfg_delay;
                beat_count  <= '0;
                otr_seen    <= 1'b0;
                timer       <= '0;
                state       <= S_CLEAR;
                adc_control <= ctrl_for(S_CLEAR, cfg_test_mode);
              end
            end
          end
          S_CLEAR: begin
            if (timer == TW'(CLEAR_CYCLES - 1)) begin
              state       <= S_ARM;
              adc_control <= ctrl_for(S_ARM, test_q);
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_ARM: begin
            if (trigger || cfg_auto_trig) begin
              if (delay_q == '0) begin
                state       <= S_CAPTURE;
                adc_control <= ctrl_for(S_CAPTURE, test_q);
              end else begin
                delay_cnt   <= delay_q;
                state       <= S_DELAY;
                adc_control <= ctrl_for(S_DELAY, test_q);
              end
            end
          end
          S_DELAY: begin
            if (delay_cnt <= ONE) begin
              state       <= S_CAPTURE;
              adc_control <= ctrl_for(S_CAPTURE, test_q);
            end else begin
              delay_cnt <= delay_cnt - ONE;
            end
          end
          S_CAPTURE: begin
            if (beat && beat_count != LEN_MAX) beat_count <= beat_count + ONE;
            if (adc_status[2]) otr_seen <= 1'b1;
            if (adc_status[1]) begin
              err_overrun  <= 1'b1;
              overrun_snap <= adc_status[31:16];
              state        <= S_ERROR;
              adc_control  <= ctrl_for(S_ERROR, test_q);
            end else if (beat && beat_count == len_q - ONE) begin
              timer       <= '0;
              state       <= S_STOP;
              adc_control <= ctrl_for(S_STOP, test_q);
            end
          end
          S_STOP: begin
            if (!adc_status[0]) begin
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
              adc_control <= '0;
            end else if (timer == TW'(STOP_TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              state       <= S_ERROR;
              adc_control <= ctrl_for(S_ERROR, test_q);
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_ERROR: begin
            if (err_clear) begin
              busy        <= 1'b0;
              state       <= S_IDLE;
              adc_control <= '0;
            end
          end
          default: begin
            busy        <= 1'b0;
            state       <= S_IDLE;
            adc_control <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb/tb_adc_capture_sequencer.sv - directed bench for adc_capture_sequencer
// Expected beat counts are queued at start and popped when done pulses.
module tb_adc_capture_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        abort;
  logic        err_clear;
  logic        trigger;
  logic        cfg_auto_trig;
  logic        cfg_test_mode;
  logic [15:0] cfg_len;
  logic [15:0] cfg_delay;
  logic [31:0] adc_status;
  logic        snoop_tvalid;
  logic        snoop_tready;
  logic [3:0]  adc_control;
  logic        busy;
  logic        done;
  logic [15:0] beat_count;
  logic        err_overrun;
  logic        err_timeout;
  logic        err_cfg;
  logic        otr_seen;
  logic [15:0] overrun_snap;
  logic [2:0]  state_out;

  logic        hold_status;
  logic        ovr;
  logic        otr;
  logic [15:0] ovr_count;
  logic        rand_ready;

  int checks;
  int errors;
  int en_cycles;
  int clr_cycles;
  int done_cnt;
  int k;
  logic [15:0] exp_q[$];
  logic [15:0] exp_beats;

  adc_capture_sequencer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .abort         (abort),
    .err_clear     (err_clear),
    .trigger       (trigger),
    .cfg_auto_trig (cfg_auto_trig),
    .cfg_test_mode (cfg_test_mode),
    .cfg_len       (cfg_len),
    .cfg_delay     (cfg_delay),
    .adc_status    (adc_status),
    .snoop_tvalid  (snoop_tvalid),
    .snoop_tready  (snoop_tready),
    .adc_control   (adc_control),
    .busy          (busy),
    .done          (done),
    .beat_count    (beat_count),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout),
    .err_cfg       (err_cfg),
    .otr_seen      (otr_seen),
    .overrun_snap  (overrun_snap),
    .state_out     (state_out)
  );

  // Streamer model: valid follows enable, status stays up while enabled.
  assign snoop_tvalid = adc_control[0];
  assign adc_status   = {ovr_count, 13'd0, otr, ovr, adc_control[0] | hold_status};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    if (rand_ready) snoop_tready = 1'($urandom_range(0, 1));
    if (adc_control[0]) en_cycles++;
    if (adc_control[2:1] == 2'b11) clr_cycles++;
    if (done) begin
      done_cnt++;
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_beats = exp_q.pop_front();
        chk("done_beat_count", 32'(beat_count), 32'(exp_beats));
      end
    end
  endtask

  task automatic clear_counts();
    en_cycles  = 0;
    clr_cycles = 0;
    done_cnt   = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    aresetn = 1'b0; start = 0; abort = 0; err_clear = 0; trigger = 0;
    cfg_auto_trig = 0; cfg_test_mode = 0; cfg_len = 0; cfg_delay = 0;
    snoop_tready = 1; hold_status = 0; ovr = 0; otr = 0; ovr_count = 0;
    rand_ready = 0;
    clear_counts();
    step(); step();
    chk("rst_ctrl", 32'(adc_control), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_beats", 32'(beat_count), 0);
    chk("rst_flags", 32'({err_overrun, err_timeout, err_cfg, otr_seen}), 0);
    chk("rst_snap", 32'(overrun_snap), 0);
    chk("rst_state", 32'(state_out), 0);
    aresetn = 1'b1;
    step();

    // Burst 1: len 8, delay 0, auto trigger, one OTR cycle mid-capture.
    clear_counts();
    cfg_len = 16'd8; cfg_delay = 0; cfg_auto_trig = 1; start = 1;
    exp_q.push_back(16'd8);
    step();
    start = 0;
    chk("b1_state_clear", 32'(state_out), 1);
    chk("b1_ctrl_clear", 32'(adc_control), 32'h6);
    chk("b1_busy", 32'(busy), 1);
    k = 0;
    while (!adc_control[0] && k < 50) begin step(); k++; end
    otr = 1; step(); otr = 0;
    k = 0;
    while (done_cnt == 0 && k < 50) begin step(); k++; end
    chk("b1_clear_cycles", 32'(clr_cycles), 4);
    chk("b1_en_cycles", 32'(en_cycles), 8);
    chk("b1_done_cnt", 32'(done_cnt), 1);
    chk("b1_state_idle", 32'(state_out), 0);
    chk("b1_otr_seen", 32'(otr_seen), 1);
    step(); step();
    chk("b1_done_once", 32'(done_cnt), 1);

    // Burst 2: delay 5 with external trigger, random tready, ignored start/trigger.
    clear_counts();
    cfg_len = 16'd3; cfg_delay = 16'd5; cfg_auto_trig = 0; start = 1; trigger = 1;
    exp_q.push_back(16'd3);
    step();
    start = 0;
    chk("b2_otr_cleared", 32'(otr_seen), 0);
    chk("b2_state_clear", 32'(state_out), 1);
    cfg_len = 16'd99; start = 1;
    step();
    start = 0; trigger = 0;
    repeat (10) step();
    chk("b2_arm_wait", 32'(state_out), 2);
    chk("b2_no_enable", 32'(en_cycles), 0);
    trigger = 1; k = 0;
    do begin step(); trigger = 0; k++; end while (!adc_control[0] && k < 20);
    chk("b2_trig_to_en", 32'(k), 6);
    rand_ready = 1;
    k = 0;
    while (done_cnt == 0 && k < 300) begin step(); k++; end
    rand_ready = 0; snoop_tready = 1;
    chk("b2_done_cnt", 32'(done_cnt), 1);

    // Burst 3: overrun after beat 3, test mode on.
    clear_counts();
    cfg_len = 16'd16; cfg_delay = 0; cfg_auto_trig = 1; cfg_test_mode = 1; start = 1;
    step();
    start = 0;
    chk("b3_ctrl_clear_tm", 32'(adc_control), 32'he);
    k = 0;
    while (beat_count != 16'd3 && k < 50) begin step(); k++; end
    chk("b3_reach_beat3", 32'(beat_count), 3);
    ovr = 1; ovr_count = 16'h0007;
    step();
    ovr = 0; ovr_count = 16'h0;
    chk("b3_err_overrun", 32'(err_overrun), 1);
    chk("b3_snap", 32'(overrun_snap), 32'h7);
    chk("b3_ctrl_err", 32'(adc_control), 32'h8);
    chk("b3_state_err", 32'(state_out), 6);
    step(); step();
    chk("b3_hold_err", 32'(state_out), 6);
    err_clear = 1; step(); err_clear = 0;
    chk("b3_clr_state", 32'(state_out), 0);
    chk("b3_clr_flags", 32'({err_overrun, err_timeout, err_cfg}), 0);
    chk("b3_clr_ctrl", 32'(adc_control), 0);
    chk("b3_no_done", 32'(done_cnt), 0);
    cfg_test_mode = 0;

    // Burst 4: stop handshake timeout.
    clear_counts();
    cfg_len = 16'd4; hold_status = 1; start = 1;
    step();
    start = 0;
    k = 0;
    while (state_out != 3'd5 && k < 50) begin step(); k++; end
    chk("b4_in_stop", 32'(state_out), 5);
    chk("b4_en_low", 32'(adc_control[0]), 0);
    k = 0;
    while (state_out == 3'd5 && k < 200) begin step(); k++; end
    chk("b4_timeout_cycles", 32'(k), 64);
    chk("b4_err_timeout", 32'(err_timeout), 1);
    chk("b4_no_done", 32'(done_cnt), 0);
    hold_status = 0;
    err_clear = 1; step(); err_clear = 0;
    chk("b4_cleared", 32'(err_timeout), 0);

    // Burst 5: zero length start.
    clear_counts();
    cfg_len = 16'd0; start = 1;
    step();
    start = 0;
    chk("b5_err_cfg", 32'(err_cfg), 1);
    chk("b5_state_err", 32'(state_out), 6);
    repeat (5) step();
    chk("b5_no_enable", 32'(en_cycles), 0);
    err_clear = 1; step(); err_clear = 0;
    chk("b5_idle", 32'(state_out), 0);

    // Burst 6: abort at beat 4 of 16 together with a start.
    clear_counts();
    cfg_len = 16'd16; cfg_delay = 16'd2; start = 1;
    step();
    start = 0;
    k = 0;
    while (beat_count != 16'd4 && k < 60) begin step(); k++; end
    chk("b6_reach_beat4", 32'(beat_count), 4);
    abort = 1; start = 1;
    step();
    abort = 0; start = 0;
    chk("b6_state", 32'(state_out), 0);
    chk("b6_ctrl", 32'(adc_control), 0);
    chk("b6_beats", 32'(beat_count), 4);
    chk("b6_busy", 32'(busy), 0);
    repeat (4) step();
    chk("b6_stay_idle", 32'(state_out), 0);
    chk("b6_no_done", 32'(done_cnt), 0);

    // Burst 7: asynchronous reset mid-capture.
    cfg_len = 16'd16; cfg_delay = 0; start = 1;
    step();
    start = 0;
    k = 0;
    while (!adc_control[0] && k < 50) begin step(); k++; end
    chk("b7_enabled", 32'(adc_control[0]), 1);
    aresetn = 0;
    #1;
    chk("b7_async_ctrl", 32'(adc_control), 0);
    chk("b7_async_state", 32'(state_out), 0);
    chk("b7_async_beats", 32'(beat_count), 0);
    step();
    aresetn = 1;
    step();
    chk("b7_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
